// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution tile streamer: FSM states and tile geometry.
package cnn_pkg;

  localparam int unsigned KER_DIM = 3;
  localparam int unsigned IMG_DIM = 4;
  localparam int unsigned OUT_DIM = IMG_DIM - KER_DIM + 1;

  localparam int unsigned KER_N = KER_DIM * KER_DIM;  // 9 weights
  localparam int unsigned IMG_N = IMG_DIM * IMG_DIM;  // 16 pixels
  localparam int unsigned OUT_N = OUT_DIM * OUT_DIM;  // 4 results

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KER,
    LOAD_IMG,
    COMPUTE,
    DRAIN
  } state_e;

endpackage

// File: rtl/conv_tile_streamer_if.sv
// Control, input-stream and output-stream signals of the convolution tile streamer.
interface conv_tile_streamer_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              ker_reuse;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  // Upstream/downstream environment driving the block
  modport master (
    output start, ker_reuse, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  // The streamer itself
  modport slave (
    input  start, ker_reuse, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/conv_tile_core.sv
// Combinational 3x3 kernel over 4x4 image MAC array producing a 2x2 result tile.
// All arithmetic is carried at DATA_W bits, so results wrap modulo 2^DATA_W.
module conv_tile_core
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [KER_N-1:0][DATA_W-1:0] ker_i,
  input  logic [IMG_N-1:0][DATA_W-1:0] img_i,
  output logic [OUT_N-1:0][DATA_W-1:0] res_o
);

  // Sum of products for each output position, row-major storage on both sides
  always_comb begin
    logic [DATA_W-1:0] acc;
    res_o = '0;
    acc   = '0;
    for (int unsigned i = 0; i < OUT_DIM; i++) begin
      for (int unsigned j = 0; j < OUT_DIM; j++) begin
        acc = '0;
        for (int unsigned r = 0; r < KER_DIM; r++) begin
          for (int unsigned c = 0; c < KER_DIM; c++) begin
            acc = acc + img_i[4'((i + r) * IMG_DIM + j + c)] * ker_i[4'(r * KER_DIM + c)];
          end
        end
        res_o[2'(i * OUT_DIM + j)] = acc;
      end
    end
  end

endmodule

// File: rtl/conv_tile_streamer.sv
// Streams a 3x3 kernel (optionally reused) and a 4x4 image in, computes the
// 2x2 valid convolution in one cycle and drains the four results out.
module conv_tile_streamer
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_tile_streamer_if.slave bus
);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ocnt_q, ocnt_d;
  logic       ker_loaded_q, ker_loaded_d;

  logic [KER_N-1:0][DATA_W-1:0] ker_q;
  logic [IMG_N-1:0][DATA_W-1:0] img_q;
  logic [OUT_N-1:0][DATA_W-1:0] res_q;
  logic [OUT_N-1:0][DATA_W-1:0] core_res;

  logic in_ready_c, out_valid_c, in_fire, out_fire;

  conv_tile_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .ker_i(ker_q),
    .img_i(img_q),
    .res_o(core_res)
  );

  // Handshake outputs derive from registered state only, so reset forces them low
  always_comb begin
    in_ready_c    = (state_q == LOAD_KER) || (state_q == LOAD_IMG);
    out_valid_c   = (state_q == DRAIN);
    in_fire       = bus.in_valid && in_ready_c;
    out_fire      = out_valid_c && bus.out_ready;
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_c;
    bus.out_last  = out_valid_c && (ocnt_q == 2'(OUT_N - 1));
    bus.out_data  = out_valid_c ? res_q[ocnt_q] : '0;
    bus.busy      = (state_q != IDLE);
  end

  // Next-state, element counters and kernel-valid flag
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ocnt_d       = ocnt_q;
    ker_loaded_d = ker_loaded_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = (bus.ker_reuse && ker_loaded_q) ? LOAD_IMG : LOAD_KER;
        end
      end
      LOAD_KER: begin
        if (in_fire) begin
          if (cnt_q == 4'(KER_N - 1)) begin
            cnt_d        = '0;
            ker_loaded_d = 1'b1;
            state_d      = LOAD_IMG;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      LOAD_IMG: begin
        if (in_fire) begin
          if (cnt_q == 4'(IMG_N - 1)) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      COMPUTE: begin
        ocnt_d  = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_fire) begin
          if (ocnt_q == 2'(OUT_N - 1)) begin
            ocnt_d  = '0;
            state_d = IDLE;
          end else begin
            ocnt_d = ocnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ocnt_q       <= '0;
      ker_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ocnt_q       <= ocnt_d;
      ker_loaded_q <= ker_loaded_d;
    end
  end

  // Kernel/image/result buffers; contents are irrelevant until loaded, so no reset
  always_ff @(posedge clk) begin
    if (in_fire && (state_q == LOAD_KER)) ker_q[cnt_q] <= bus.in_data;
    if (in_fire && (state_q == LOAD_IMG)) img_q[cnt_q] <= bus.in_data;
    if (state_q == COMPUTE) res_q <= core_res;
  end

endmodule

// File: tb/tb_conv_tile_streamer.sv
// Directed scoreboard bench for conv_tile_streamer.
module tb_conv_tile_streamer;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [DW:0] sb_q[$];  // {last, data}

  conv_tile_streamer_if #(.DATA_W(DW)) bus ();

  conv_tile_streamer #(.DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    sb_q.push_back({1'b0, a});
    sb_q.push_back({1'b0, b});
    sb_q.push_back({1'b0, c});
    sb_q.push_back({1'b1, d});
  endtask

  task automatic start_tile(input logic reuse);
    bus.start = 1'b1;
    bus.ker_reuse = reuse;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ker_reuse = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("in_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_ker(input logic [DW-1:0] w, input bit gaps);
    for (int k = 0; k < 9; k++) send_byte(w, gaps);
  endtask

  // Image of constant fill (fill=1) or ramp from base; checks two-cycle latency
  task automatic send_img(input logic [DW-1:0] base, input bit fill, input bit gaps);
    for (int k = 0; k < 16; k++) send_byte(fill ? base : base + DW'(k), gaps);
    chk("lat_compute_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_drain_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain(input bit toggle, input bit start_mid);
    int got;
    bit stalled;
    logic [DW:0] held, exp;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      bus.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      bus.start = start_mid && (cyc == 1);
      if (stalled) chk("stall_stable", 32'({bus.out_last, bus.out_data}), 32'(held));
      if (bus.out_valid && bus.out_ready) begin
        exp = sb_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(exp[DW-1:0]));
        chk("out_last", 32'(bus.out_last), 32'(exp[DW]));
        stalled = 1'b0;
        got++;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held = {bus.out_last, bus.out_data};
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    chk("drain_count", 32'(got), 32'd4);
    chk("idle_after_drain", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ker_reuse = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // Kernel of ones over ramp 1..16; reuse requested before any kernel exists
    start_tile(1'b1);
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_in_ready", 32'(bus.in_ready), 32'd1);
    push4(8'd54, 8'd63, 8'd90, 8'd99);
    send_ker(8'd1, 1'b0);
    send_img(8'd1, 1'b0, 1'b0);
    drain(1'b0, 1'b0);

    // All-255 operands wrap to 9
    start_tile(1'b0);
    push4(8'd9, 8'd9, 8'd9, 8'd9);
    send_ker(8'd255, 1'b0);
    send_img(8'd255, 1'b1, 1'b0);
    drain(1'b0, 1'b0);

    // Ones kernel again, then reuse it with ramp 2..17
    start_tile(1'b0);
    push4(8'd54, 8'd63, 8'd90, 8'd99);
    send_ker(8'd1, 1'b0);
    send_img(8'd1, 1'b0, 1'b0);
    drain(1'b0, 1'b0);
    start_tile(1'b1);
    push4(8'd63, 8'd72, 8'd99, 8'd108);
    send_img(8'd2, 1'b0, 1'b0);
    drain(1'b0, 1'b0);

    // Stray in_valid in IDLE, then gapped input and toggling out_ready
    bus.in_valid = 1'b1;
    bus.in_data = 8'd77;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    start_tile(1'b1);
    push4(8'd54, 8'd63, 8'd90, 8'd99);
    send_img(8'd1, 1'b0, 1'b1);
    drain(1'b1, 1'b0);

    // Reset mid-image, then reuse request must reload the kernel
    start_tile(1'b1);
    for (int k = 0; k < 5; k++) send_byte(8'd50, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 32'(bus.busy), 32'd0);
    start_tile(1'b1);
    push4(8'd108, 8'd126, 8'd180, 8'd198);
    send_ker(8'd2, 1'b0);
    send_img(8'd1, 1'b0, 1'b0);
    drain(1'b0, 1'b0);

    // start pulsed during DRAIN is ignored
    start_tile(1'b1);
    push4(8'd108, 8'd126, 8'd180, 8'd198);
    send_img(8'd1, 1'b0, 1'b0);
    drain(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("after_drain_busy", 32'(bus.busy), 32'd0);
    chk("after_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
